// File: rtl/frame_rx_pkg.sv
// Shared constants, FSM state type and row-byte decode helpers
// for the 8x8 serial frame receiver.
package frame_rx_pkg;

    localparam int ROWS       = 8;
    localparam int COLS       = 8;
    localparam int DEPTH_BITS = 2;
    localparam int LINE_BITS  = 16;
    localparam int FRAME_BITS = ROWS * COLS * DEPTH_BITS;

    typedef enum logic {
        HUNT,
        ACCUM
    } state_t;

    // A row byte selects its row by holding exactly one bit low.
    function automatic logic row_valid(input logic [7:0] sel);
        return $onehot(~sel);
    endfunction

    function automatic logic [2:0] row_index(input logic [7:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/frame_receiver_8x8_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect on the last stage
// against a one-flop delayed copy.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_dly;

endmodule

// File: rtl/frame_receiver_8x8.sv
// Serial 16-bit line receiver that latches row bytes and accumulates
// PASSES binary passes into a 2-bit-per-pixel 8x8 frame.
module frame_receiver_8x8
    import frame_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PASSES      = 4
) (
    input  logic                  clk,
    input  logic                  _rst,
    input  logic                  sclk,
    input  logic                  rclk,
    input  logic                  _srclr,
    input  logic                  serial_data,
    output logic [LINE_BITS-1:0]  latch_q,
    output logic                  latch_strobe,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  row_error,
    output logic                  locked
);

    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    logic [SYNC_STAGES-1:0] r_srclr_sync;
    logic [SYNC_STAGES-1:0] r_sdata_sync;
    logic [LINE_BITS-1:0]   r_shift;
    logic [LINE_BITS-1:0]   r_latch;
    logic [FRAME_BITS-1:0]  r_acc;
    logic [FRAME_BITS-1:0]  r_frame;
    logic [PW-1:0]          r_pass;
    logic                   r_strobe;
    logic                   r_fvalid;
    logic                   r_rowerr;
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_sclk_rise;
    logic                   w_rclk_rise;
    logic                   w_valid;
    logic [2:0]             w_row;
    logic                   w_row7;
    logic                   w_last;
    logic [FRAME_BITS-1:0]  w_acc_sum;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk     (clk),
        .i_rst_n (_rst),
        .i_async (sclk),
        .o_rise  (w_sclk_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_rclk (
        .clk     (clk),
        .i_rst_n (_rst),
        .i_async (rclk),
        .o_rise  (w_rclk_rise)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_srclr_sync <= '0;
            r_sdata_sync <= '0;
        end else begin
            r_srclr_sync <= {r_srclr_sync[SYNC_STAGES-2:0], _srclr};
            r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], serial_data};
        end
    end

    // Decode works on the word about to be latched (pre-shift value).
    assign w_valid = row_valid(r_shift[15:8]);
    assign w_row   = row_index(r_shift[15:8]);
    assign w_row7  = w_valid && (w_row == 3'd7);
    assign w_last  = (r_pass == PW'(PASSES - 1));

    always_comb begin
        w_acc_sum = r_acc;
        for (int c = 0; c < COLS; c++) begin
            if (r_shift[c] &&
                w_acc_sum[(int'(w_row)*COLS + c)*DEPTH_BITS +: DEPTH_BITS] != 2'b11) begin
                w_acc_sum[(int'(w_row)*COLS + c)*DEPTH_BITS +: DEPTH_BITS] =
                    w_acc_sum[(int'(w_row)*COLS + c)*DEPTH_BITS +: DEPTH_BITS] + 2'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_rclk_rise) begin
            if (!w_valid)    w_state_nxt = HUNT;
            else if (w_row7) w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) r_state <= HUNT;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_shift <= '0;
        end else if (!r_srclr_sync[SYNC_STAGES-1]) begin
            r_shift <= '0;
        end else if (w_sclk_rise) begin
            r_shift <= {r_shift[LINE_BITS-2:0], r_sdata_sync[SYNC_STAGES-1]};
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_latch  <= '0;
            r_acc    <= '0;
            r_frame  <= '0;
            r_pass   <= '0;
            r_strobe <= 1'b0;
            r_fvalid <= 1'b0;
            r_rowerr <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_fvalid <= 1'b0;
            r_rowerr <= 1'b0;
            if (w_rclk_rise) begin
                r_latch  <= r_shift;
                r_strobe <= 1'b1;
                if (!w_valid) begin
                    r_rowerr <= 1'b1;
                end else if (r_state == HUNT) begin
                    if (w_row7) begin
                        r_acc  <= '0;
                        r_pass <= '0;
                    end
                end else if (w_row7 && w_last) begin
                    r_frame  <= w_acc_sum;
                    r_fvalid <= 1'b1;
                    r_acc    <= '0;
                    r_pass   <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    if (w_row7) r_pass <= r_pass + PW'(1);
                end
            end
        end
    end

    assign latch_q      = r_latch;
    assign latch_strobe = r_strobe;
    assign frame_data   = r_frame;
    assign frame_valid  = r_fvalid;
    assign row_error    = r_rowerr;
    assign locked       = (r_state == ACCUM);

endmodule

// File: tb/tb_frame_receiver_8x8.sv
// Directed bench for frame_receiver_8x8: latching, clear, tied edges,
// frame accumulation, row errors and mid-frame reset.
module tb_frame_receiver_8x8;

    logic         clk = 1'b0;
    logic         _rst;
    logic         sclk;
    logic         rclk;
    logic         _srclr;
    logic         serial_data;
    logic [15:0]  latch_q;
    logic         latch_strobe;
    logic [127:0] frame_data;
    logic         frame_valid;
    logic         row_error;
    logic         locked;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_fv = 0;
    int n_err = 0;
    int n_orphan = 0;
    int s0, f0, e0;

    logic [127:0] exp_frame;
    logic [15:0]  w_tmp;

    frame_receiver_8x8 dut (
        .clk          (clk),
        ._rst         (_rst),
        .sclk         (sclk),
        .rclk         (rclk),
        ._srclr       (_srclr),
        .serial_data  (serial_data),
        .latch_q      (latch_q),
        .latch_strobe (latch_strobe),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .row_error    (row_error),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_strobe += int'(latch_strobe);
        n_fv     += int'(frame_valid);
        n_err    += int'(row_error);
        if (frame_valid && !latch_strobe) n_orphan++;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b, input logic tie);
        serial_data = b;
        tick(3);
        sclk = 1'b1;
        if (tie) rclk = 1'b1;
        tick(3);
        sclk = 1'b0;
        rclk = 1'b0;
    endtask

    task automatic shift_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) shift_bit(w[i], 1'b0);
    endtask

    task automatic pulse_rclk();
        tick(3);
        rclk = 1'b1;
        tick(3);
        rclk = 1'b0;
        tick(4);
    endtask

    function automatic logic [1:0] dens(input int r, input int c);
        logic [1:0] row0 [8];
        row0 = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3};
        if (r == 0) return row0[c];
        return 2'((r * 3 + c) % 4);
    endfunction

    function automatic logic [15:0] row_word(input int r, input int p);
        logic [15:0] w;
        w = 16'hFF00;
        w[8 + r] = 1'b0;
        for (int c = 0; c < 8; c++) w[c] = (int'(dens(r, c)) > p);
        return w;
    endfunction

    task automatic send_row(input int r, input int p);
        shift_word(row_word(r, p));
        pulse_rclk();
    endtask

    task automatic send_pass(input int p);
        for (int r = 0; r < 8; r++) send_row(r, p);
    endtask

    initial begin
        _rst = 1'b0;
        sclk = 1'b0;
        rclk = 1'b0;
        _srclr = 1'b1;
        serial_data = 1'b0;
        exp_frame = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_frame[(r*8 + c)*2 +: 2] = dens(r, c);

        tick(5);
        check("rst_latch_q", 128'(latch_q), 128'h0);
        check("rst_frame", frame_data, 128'h0);
        check("rst_locked", 128'(locked), 128'h0);
        check("rst_pulses", 128'(n_strobe + n_fv + n_err), 128'h0);
        _rst = 1'b1;
        tick(4);

        s0 = n_strobe; e0 = n_err;
        shift_word(16'hFE81);
        pulse_rclk();
        check("latch_fe81", 128'(latch_q), 128'hFE81);
        check("strobe_once", 128'(n_strobe - s0), 128'd1);
        check("row0_no_err", 128'(n_err - e0), 128'd0);
        check("row0_hunt", 128'(locked), 128'h0);

        _srclr = 1'b0;
        tick(4);
        shift_word(16'hFFFF);
        _srclr = 1'b1;
        tick(4);
        e0 = n_err;
        pulse_rclk();
        check("srclr_latch", 128'(latch_q), 128'h0);
        check("srclr_rowerr", 128'(n_err - e0), 128'd1);

        w_tmp = 16'hA5C3;
        shift_word(w_tmp);
        s0 = n_strobe;
        shift_bit(1'b1, 1'b1);
        tick(4);
        check("tied_1st", 128'(latch_q), 128'hA5C3);
        shift_bit(1'b0, 1'b1);
        tick(4);
        check("tied_2nd", 128'(latch_q), 128'h4B87);
        check("tied_strobes", 128'(n_strobe - s0), 128'd2);

        f0 = n_fv;
        send_row(7, 3);
        check("sync_locked", 128'(locked), 128'h1);
        send_pass(0);
        send_pass(1);
        send_pass(2);
        for (int r = 0; r < 7; r++) send_row(r, 3);
        check("frame_not_yet", 128'(n_fv - f0), 128'd0);
        send_row(7, 3);
        check("frame_valid_once", 128'(n_fv - f0), 128'd1);
        check("frame_data", frame_data, exp_frame);
        check("locked_after_frame", 128'(locked), 128'h1);

        f0 = n_fv; e0 = n_err;
        send_row(0, 0);
        send_row(1, 0);
        shift_word(16'hFC00);
        pulse_rclk();
        check("err_pulse", 128'(n_err - e0), 128'd1);
        check("err_unlocked", 128'(locked), 128'h0);
        check("err_frame_held", frame_data, exp_frame);
        send_pass(3);
        send_pass(0);
        send_pass(1);
        send_pass(2);
        check("err_no_frame", 128'(n_fv - f0), 128'd0);
        send_pass(3);
        check("err_resync_frame", 128'(n_fv - f0), 128'd1);
        check("err_frame_data", frame_data, exp_frame);

        send_pass(0);
        send_pass(1);
        _rst = 1'b0;
        tick(3);
        check("midrst_frame", frame_data, 128'h0);
        check("midrst_latch", 128'(latch_q), 128'h0);
        check("midrst_locked", 128'(locked), 128'h0);
        _rst = 1'b1;
        tick(4);
        f0 = n_fv;
        send_pass(2);
        send_pass(3);
        send_pass(0);
        send_pass(1);
        check("rst_no_frame", 128'(n_fv - f0), 128'd0);
        send_pass(2);
        check("rst_resync_frame", 128'(n_fv - f0), 128'd1);
        check("rst_frame_data", frame_data, exp_frame);
        check("fv_with_strobe", 128'(n_orphan), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
